// File: rtl/bus_arbiter.sv
// RAM arbiter between the CPU and NCHAN DMA channels. Each DMA tenure lasts at most BURST cycles.
// Define BUS_ARB_ROUND_ROBIN_EN to get round-robin winner selection. The default is fixed priority, lowest channel first.
//   state  | meaning
//   S_IDLE | CPU owns the RAM port
//   S_DMA  | channel r_grant owns the RAM port, r_cnt = cycles granted so far
module bus_arbiter #(
    parameter int NCHAN = 4,
    parameter int BURST = 4,
    parameter int AW    = 22
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  bus_arbitrate,
    input  logic [AW-1:0]         cpu_addr,
    input  logic [15:0]           cpu_data_in,
    input  logic                  cpu_rd,
    input  logic                  cpu_wr,
    input  logic                  cpu_byte_op,
    input  logic [NCHAN-1:0]      dma_req,
    input  logic [NCHAN*AW-1:0]   dma_addr,
    input  logic [NCHAN*16-1:0]   dma_data_out,
    input  logic [NCHAN-1:0]      dma_rd,
    input  logic [NCHAN-1:0]      dma_wr,
    output logic                  bus_ack,
    output logic [NCHAN-1:0]      dma_ack,
    output logic [2:0]            grant_chan,
    output logic [AW-1:0]         ram_addr,
    output logic [15:0]           ram_data_out,
    output logic                  ram_rd,
    output logic                  ram_wr,
    output logic                  ram_byte_op
);

    typedef enum logic {S_IDLE = 1'b0, S_DMA = 1'b1} state_t;

    state_t       r_state;
    logic [3:0]   r_cnt;
    logic [2:0]   r_grant;

    logic [2:0]   w_win;
    logic         w_req_cur;
    logic [AW-1:0] w_dma_addr;
    logic [15:0]  w_dma_data;
    logic         w_dma_rd;
    logic         w_dma_wr;

`ifdef BUS_ARB_ROUND_ROBIN_EN
    // Until the first grant after reset, the search starts at channel 0, so the grant order is 0,1,2,...
    logic         r_seen;
    logic [3:0]   w_start;
    logic         w_found;

    always_comb begin
        w_win   = 3'd0;
        w_found = 1'b0;
        w_start = r_seen ? ({1'b0, r_grant} + 4'd1) : 4'd0;
        for (int k = 0; k < NCHAN; k++) begin
            for (int j = 0; j < NCHAN; j++) begin
                if (!w_found && dma_req[j] && (j == (int'(w_start) + k) % NCHAN)) begin
                    w_win   = 3'(j);
                    w_found = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_seen <= 1'b0;
        else if (r_state == S_IDLE && bus_arbitrate && (|dma_req))
            r_seen <= 1'b1;
    end
`else
    always_comb begin
        w_win = 3'd0;
        for (int j = NCHAN - 1; j >= 0; j--) begin
            if (dma_req[j])
                w_win = 3'(j);
        end
    end
`endif

    always_comb begin
        w_req_cur  = 1'b0;
        w_dma_addr = '0;
        w_dma_data = 16'd0;
        w_dma_rd   = 1'b0;
        w_dma_wr   = 1'b0;
        for (int i = 0; i < NCHAN; i++) begin
            if (r_grant == 3'(i)) begin
                w_req_cur  = dma_req[i];
                w_dma_addr = dma_addr[i*AW +: AW];
                w_dma_data = dma_data_out[i*16 +: 16];
                w_dma_rd   = dma_rd[i];
                w_dma_wr   = dma_wr[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_grant <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus_arbitrate && (|dma_req)) begin
                        r_state <= S_DMA;
                        r_cnt   <= 4'd1;
                        r_grant <= w_win;
                    end
                end
                S_DMA: begin
                    if (w_req_cur && (r_cnt < 4'(BURST))) begin
                        r_cnt <= r_cnt + 4'd1;
                    end else begin
                        r_state <= S_IDLE;
                        r_cnt   <= 4'd0;
                    end
                end
            endcase
        end
    end

    // The RAM port is a pure mux on the state, so an asynchronous reset hands it back to the CPU at once.
    always_comb begin
        bus_ack     = (r_state == S_IDLE);
        dma_ack     = '0;
        ram_addr    = cpu_addr;
        ram_data_out = cpu_data_in;
        ram_rd      = cpu_rd;
        ram_wr      = cpu_wr;
        ram_byte_op = cpu_byte_op;
        if (r_state == S_DMA) begin
            for (int i = 0; i < NCHAN; i++)
                dma_ack[i] = (r_grant == 3'(i));
            ram_addr     = w_dma_addr;
            ram_data_out = w_dma_data;
            ram_rd       = w_dma_rd;
            ram_wr       = w_dma_wr;
            ram_byte_op  = 1'b0;
        end
    end

    assign grant_chan = r_grant;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: a tenure-level model checked every cycle, plus directed literal checks.
// A second instance with BURST=1 confirms that every tenure lasts one cycle.
`timescale 1ns/1ps
module tb_bus_arbiter;
    localparam int N = 4;
    localparam int B = 4;
    localparam int A = 22;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             bus_arbitrate;
    logic [A-1:0]     cpu_addr;
    logic [15:0]      cpu_data_in;
    logic             cpu_rd, cpu_wr, cpu_byte_op;
    logic [N-1:0]     dma_req;
    logic [N*A-1:0]   dma_addr;
    logic [N*16-1:0]  dma_data_out;
    logic [N-1:0]     dma_rd, dma_wr;

    logic             bus_ack;
    logic [N-1:0]     dma_ack;
    logic [2:0]       grant_chan;
    logic [A-1:0]     ram_addr;
    logic [15:0]      ram_data_out;
    logic             ram_rd, ram_wr, ram_byte_op;

    logic             b1_bus_ack;
    logic [N-1:0]     b1_dma_ack;
    logic [2:0]       b1_grant_chan;
    logic [A-1:0]     b1_ram_addr;
    logic [15:0]      b1_ram_data_out;
    logic             b1_ram_rd, b1_ram_wr, b1_ram_byte_op;

    int n_checks = 0;
    int n_errors = 0;
    logic chk_on = 1'b0;

    always #5 clk = ~clk;

    bus_arbiter #(.NCHAN(N), .BURST(B), .AW(A)) u_dut (
        .clk(clk), .reset_n(reset_n), .bus_arbitrate(bus_arbitrate),
        .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_byte_op(cpu_byte_op), .dma_req(dma_req), .dma_addr(dma_addr),
        .dma_data_out(dma_data_out), .dma_rd(dma_rd), .dma_wr(dma_wr),
        .bus_ack(bus_ack), .dma_ack(dma_ack), .grant_chan(grant_chan),
        .ram_addr(ram_addr), .ram_data_out(ram_data_out), .ram_rd(ram_rd),
        .ram_wr(ram_wr), .ram_byte_op(ram_byte_op)
    );

    bus_arbiter #(.NCHAN(N), .BURST(1), .AW(A)) u_dut_b1 (
        .clk(clk), .reset_n(reset_n), .bus_arbitrate(bus_arbitrate),
        .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_byte_op(cpu_byte_op), .dma_req(dma_req), .dma_addr(dma_addr),
        .dma_data_out(dma_data_out), .dma_rd(dma_rd), .dma_wr(dma_wr),
        .bus_ack(b1_bus_ack), .dma_ack(b1_dma_ack), .grant_chan(b1_grant_chan),
        .ram_addr(b1_ram_addr), .ram_data_out(b1_ram_data_out), .ram_rd(b1_ram_rd),
        .ram_wr(b1_ram_wr), .ram_byte_op(b1_ram_byte_op)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_owner is the owning channel (-1 means the CPU owns the RAM), m_len is the length of the current tenure, m_last is the last channel granted.
    int m_owner = -1;
    int m_len   = 0;
    int m_last  = -1;

    function automatic int pick(input logic [N-1:0] req, input int last);
        int c;
`ifdef BUS_ARB_ROUND_ROBIN_EN
        for (int k = 0; k < N; k++) begin
            c = (last + 1 + k) % N;
            if (req[c]) return c;
        end
`else
        for (c = 0; c < N; c++)
            if (req[c]) return c;
`endif
        return 0;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_owner <= -1;
            m_len   <= 0;
            m_last  <= -1;
        end else if (m_owner < 0) begin
            if (bus_arbitrate && dma_req != '0) begin
                m_owner <= pick(dma_req, m_last);
                m_last  <= pick(dma_req, m_last);
                m_len   <= 1;
            end
        end else if (dma_req[m_owner] && m_len < B) begin
            m_len <= m_len + 1;
        end else begin
            m_owner <= -1;
        end
    end

    logic [N-1:0] b1_prev = '0;

    always @(negedge clk) begin
        if (chk_on) begin
            if (m_owner < 0) begin
                check("bus_ack", 32'(bus_ack), 32'd1);
                check("dma_ack", 32'(dma_ack), 32'd0);
                check("ram_addr", 32'(ram_addr), 32'(cpu_addr));
                check("ram_data", 32'(ram_data_out), 32'(cpu_data_in));
                check("ram_rd", 32'(ram_rd), 32'(cpu_rd));
                check("ram_wr", 32'(ram_wr), 32'(cpu_wr));
                check("ram_byte_op", 32'(ram_byte_op), 32'(cpu_byte_op));
            end else begin
                check("bus_ack", 32'(bus_ack), 32'd0);
                check("dma_ack", 32'(dma_ack), 32'd1 << m_owner);
                check("ram_addr", 32'(ram_addr), 32'(dma_addr[m_owner*A +: A]));
                check("ram_data", 32'(ram_data_out), 32'(dma_data_out[m_owner*16 +: 16]));
                check("ram_rd", 32'(ram_rd), 32'(dma_rd[m_owner]));
                check("ram_wr", 32'(ram_wr), 32'(dma_wr[m_owner]));
                check("ram_byte_op", 32'(ram_byte_op), 32'd0);
            end
            check("grant_chan", 32'(grant_chan), (m_last < 0) ? 32'd0 : 32'(m_last));
            check("b1_onehot0", 32'($onehot0(b1_dma_ack)), 32'd1);
            check("b1_bus_ack", 32'(b1_bus_ack), 32'(b1_dma_ack == '0));
            if (b1_prev != '0)
                check("b1_single_cycle", 32'(b1_dma_ack), 32'd0);
            b1_prev = b1_dma_ack;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_pulse();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

`ifdef BUS_ARB_ROUND_ROBIN_EN
    int seq_many[21] = '{1,1,1,1,0, 2,2,2,2,0, 4,4,4,4,0, 8,8,8,8,0, 1};
`else
    int seq_many[21] = '{1,1,1,1,0, 1,1,1,1,0, 1,1,1,1,0, 1,1,1,1,0, 1};
`endif
    int seq_burst[6] = '{2,2,2,2,0,2};
    int seq_b1[6]    = '{2,0,2,0,2,0};

    initial begin
        reset_n       = 1'b0;
        bus_arbitrate = 1'b1;
        cpu_addr      = 22'o1000;
        cpu_data_in   = 16'h1234;
        cpu_rd        = 1'b1;
        cpu_wr        = 1'b0;
        cpu_byte_op   = 1'b1;
        dma_req       = 4'b1111;
        for (int i = 0; i < N; i++) begin
            dma_addr[i*A +: A]       = 22'h100000 | 22'(i * 32'h111);
            dma_data_out[i*16 +: 16] = 16'hA000 + 16'(i);
        end
        dma_rd = 4'b0101;
        dma_wr = 4'b1010;
        chk_on = 1'b1;

        // Reset state, with requests pending that must be ignored
        step();
        step();
        check("rst_bus_ack", 32'(bus_ack), 32'd1);
        check("rst_dma_ack", 32'(dma_ack), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'o1000);
        check("rst_ram_rd", 32'(ram_rd), 32'd1);
        dma_req       = 4'b0000;
        bus_arbitrate = 1'b0;
        reset_n       = 1'b1;
        step();

        // Full burst followed by one CPU cycle and a re-grant
        dma_req       = 4'b0010;
        bus_arbitrate = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("burst_seq", 32'(dma_ack), 32'(seq_burst[i]));
            check("b1_seq", 32'(b1_dma_ack), 32'(seq_b1[i]));
        end

        // Early termination: the request drops during the 2nd grant cycle
        step();
        check("early_2nd", 32'(dma_ack), 32'd2);
        dma_req = 4'b0000;
        step();
        check("early_idle_ack", 32'(dma_ack), 32'd0);
        check("early_idle_bus", 32'(bus_ack), 32'd1);

        // All channels requesting
        reset_pulse();
        dma_req = 4'b1111;
        for (int i = 0; i < 21; i++) begin
            step();
            check("multi_seq", 32'(dma_ack), 32'(seq_many[i]));
        end
        check("multi_grant_end", 32'(grant_chan), 32'd0);

        // Hold-off while bus_arbitrate is low
        reset_pulse();
        dma_req       = 4'b0001;
        bus_arbitrate = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("holdoff_ack", 32'(dma_ack), 32'd0);
        end
        bus_arbitrate = 1'b1;
        step();
        check("holdoff_grant", 32'(dma_ack), 32'd1);

        // Asynchronous abort at cnt=2
        reset_pulse();
        dma_req = 4'b0010;
        step();
        step();
        check("abort_pre_ack", 32'(dma_ack), 32'd2);
        check("abort_pre_wr", 32'(ram_wr), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("abort_ack", 32'(dma_ack), 32'd0);
        check("abort_bus", 32'(bus_ack), 32'd1);
        check("abort_wr", 32'(ram_wr), 32'd0);
        check("abort_addr", 32'(ram_addr), 32'o1000);
        cpu_wr = 1'b1;
        #1;
        check("abort_wr_follow", 32'(ram_wr), 32'd1);
        step();
        cpu_wr  = 1'b0;
        reset_n = 1'b1;
        step();
        check("post_reset_grant", 32'(dma_ack), 32'd2);

        step();
        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
